dm_rmw_unit: RTL

Data-memory stage block for the pipelined RISC-V core: accepts one load/store request per transaction from the MEM stage (byte address, store data, DMType), owns a word-wide single-port synchronous RAM without byte enables, and returns aligned, extended load data. Sub-word stores are implemented as read-modify-write. Misaligned or illegal-type accesses are rejected with an error response and no memory side effect.

---
 rtl/dm_rmw_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dm_rmw_unit.sv
// Data-memory stage: word RAM with sub-word read-modify-write stores,
// aligned/extended loads and error responses for bad accesses.
module dm_rmw_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_dmtype,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] widx_q;
    logic [1:0]            off_q;
    logic [31:0]           wdata_q;
    logic [2:0]            dmt_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;

    logic [31:0]           mem [0:(2**ADDR_WIDTH)-1];
    logic [31:0]           ram_q;

    logic                  accept;
    logic                  bad;
    logic                  word_st;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [31:0]           ram_wdata;
    logic [31:0]           ext;
    logic [31:0]           merged;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic                  unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = rst && (state_q == S_IDLE);
    assign accept    = req_ready && req_valid;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        bad = 1'b0;
        unique case (req_dmtype)
            3'b000:         bad = |req_addr[1:0];
            3'b001, 3'b010: bad = req_addr[0];
            3'b011, 3'b100: bad = 1'b0;
            default:        bad = 1'b1;
        endcase
    end

    assign word_st = req_we && (req_dmtype == 3'b000);

    // Single port: IDLE drives the incoming address, RD_WAIT the latched one.
    assign ram_idx   = (state_q == S_IDLE) ? req_addr[ADDR_WIDTH+1:2] : widx_q;
    assign ram_wdata = (state_q == S_IDLE) ? req_wdata : merged;
    assign ram_re    = accept && !bad && !word_st;
    assign ram_we    = rst && ((accept && !bad && word_st) ||
                               (state_q == S_RD_WAIT && we_q));

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= ram_wdata;
        if (ram_re) ram_q <= mem[ram_idx];
    end

    assign byte_v = ram_q[{off_q, 3'b000} +: 8];
    assign half_v = off_q[1] ? ram_q[31:16] : ram_q[15:0];

    always_comb begin
        ext    = ram_q;
        merged = ram_q;
        unique case (dmt_q)
            3'b001: begin
                ext = {{16{half_v[15]}}, half_v};
                merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            3'b010: begin
                ext = {16'h0, half_v};
                merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            3'b011: begin
                ext = {{24{byte_v[7]}}, byte_v};
                merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            3'b100: begin
                ext = {24'h0, byte_v};
                merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (accept) state_d = (bad || word_st) ? S_RESP : S_RD_WAIT;
            S_RD_WAIT: state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            widx_q      <= '0;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0;
            dmt_q       <= 3'b000;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        we_q        <= req_we;
                        widx_q      <= req_addr[ADDR_WIDTH+1:2];
                        off_q       <= req_addr[1:0];
                        wdata_q     <= req_wdata;
                        dmt_q       <= req_dmtype;
                        rsp_err_q   <= bad;
                        rsp_rdata_q <= 32'h0;
                    end
                end
                S_RD_WAIT: begin
                    if (!we_q) rsp_rdata_q <= ext;
                end
                S_RESP: begin
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
